cordic_rr_arbiter: RTL and testbench

Round-robin scheduler that shares one serial CORDIC cos/sin engine between `NREQ` requesters. It accepts angle requests over per-requester valid/ready handshakes, issues a one-cycle start pulse to the engine, and waits for the engine's ready. It then holds the result for the owning requester until that requester consumes it. The block sits between the angle sources (NCOs, phase accumulators) and the single engine instance, which remains a separate module wired to the `eng*` ports.

---
 rtl/cordic_arb_pkg.sv | 45 ++++
 rtl/cordic_rr_arbiter_rr_pick.sv | 22 ++
 rtl/cordic_rr_arbiter.sv | 136 +++++++++++++
 tb/tb_cordic_rr_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_arb_pkg.sv
// Shared types and the round-robin search used by the shared-engine schedulers.
package cordic_arb_pkg;

  localparam int unsigned RR_MAX   = 16;
  localparam int unsigned RR_IDX_W = 4;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_START,
    S_RUN,
    S_DELIVER
  } arb_state_t;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_grant_t;

  // First set bit of valid searching upward from (ptr+1) mod nreq, wrapping.
  function automatic rr_grant_t rr_next(
    input logic [RR_MAX-1:0]   valid,
    input logic [RR_IDX_W-1:0] ptr,
    input int unsigned         nreq
  );
    rr_grant_t           g;
    int unsigned         p;
    int unsigned         cand;
    logic [RR_IDX_W-1:0] c;
    g = '0;
    p = 32'(ptr);
    for (int unsigned off = 1; off <= RR_MAX; off++) begin
      if (off <= nreq && !g.found) begin
        cand = (p + off) % nreq;
        c    = cand[RR_IDX_W-1:0];
        if (valid[c]) begin
          g.found = 1'b1;
          g.idx   = c;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/cordic_rr_arbiter_rr_pick.sv
// NREQ-wide rotate-priority encoder: picks the next requester after ptr_i.
module rr_pick
  import cordic_arb_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic            found_o,
  output logic [IDW-1:0]  idx_o,
  output logic [NREQ-1:0] onehot_o
);

  rr_grant_t g;

  assign g        = rr_next(RR_MAX'(valid_i), RR_IDX_W'(ptr_i), NREQ);
  assign found_o  = g.found;
  assign idx_o    = g.idx[IDW-1:0];
  assign onehot_o = g.found ? NREQ'(RR_MAX'(1) << g.idx) : '0;

endmodule

// File: rtl/cordic_rr_arbiter.sv
// Round-robin front end sharing one serial CORDIC cos/sin engine between
// NREQ angle sources; one job in flight, result held until the owner takes it.
module cordic_rr_arbiter
  import cordic_arb_pkg::*;
#(
  parameter  int unsigned NREQ      = 4,
  parameter  int unsigned PHI_WIDTH = 16,
  parameter  int unsigned N         = 12,
  localparam int unsigned IDW       = $clog2(NREQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             reqValid,
  input  logic [NREQ*PHI_WIDTH-1:0]   reqPhi,
  output logic [NREQ-1:0]             reqReady,
  output logic [NREQ-1:0]             resValid,
  input  logic [NREQ-1:0]             resReady,
  output logic signed [PHI_WIDTH-1:0] resCos,
  output logic signed [PHI_WIDTH-1:0] resSin,
  output logic [IDW-1:0]              resId,
  output logic                        busy,
  output logic                        engSt,
  output logic [PHI_WIDTH-1:0]        engPhi,
  input  logic                        engRdy,
  input  logic signed [PHI_WIDTH-1:0] engCos,
  input  logic signed [PHI_WIDTH-1:0] engSin
);

  if (NREQ < 2 || NREQ > RR_MAX || N < 1) begin : g_bad_param
    $error("cordic_rr_arbiter: NREQ must be 2..16 and N at least 1");
  end

  arb_state_t                  state_q, state_d;
  logic [IDW-1:0]              ptr_q, ptr_d;
  logic [IDW-1:0]              owner_q, owner_d;
  logic [PHI_WIDTH-1:0]        phi_q, phi_d;
  logic                        st_q, st_d;
  logic signed [PHI_WIDTH-1:0] cos_q, cos_d;
  logic signed [PHI_WIDTH-1:0] sin_q, sin_d;

  logic [PHI_WIDTH-1:0] req_phi_arr [NREQ];
  logic                 pick_found;
  logic [IDW-1:0]       pick_idx;
  logic [NREQ-1:0]      pick_onehot;
  logic [NREQ-1:0]      owner_onehot;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_phi
    assign req_phi_arr[gi] = reqPhi[gi*PHI_WIDTH +: PHI_WIDTH];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .valid_i  (reqValid),
    .ptr_i    (ptr_q),
    .found_o  (pick_found),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot)
  );

  assign owner_onehot = NREQ'(1) << owner_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      ptr_q   <= IDW'(NREQ - 1);
      owner_q <= '0;
      phi_q   <= '0;
      st_q    <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
    end else begin
      // NOTE: registers take <= so every update in this block sees pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      phi_q   <= phi_d;
      st_q    <= st_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
    end
  end

  always_comb begin
    // NOTE: every next-state and output gets a default first so no path infers a latch.
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    phi_d    = phi_q;
    st_d     = 1'b0;
    cos_d    = cos_q;
    sin_d    = sin_q;
    reqReady = '0;
    resValid = '0;

    unique case (state_q)
      S_INIT: begin
        if (engRdy) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (pick_found) begin
          reqReady = pick_onehot;
          phi_d    = req_phi_arr[pick_idx];
          owner_d  = pick_idx;
          st_d     = 1'b1;
          state_d  = S_START;
        end
      end
      S_START: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        // engRdy is still high from the previous job during S_START, so only look here.
        if (engRdy) begin
          cos_d   = engCos;
          sin_d   = engSin;
          state_d = S_DELIVER;
        end
      end
      S_DELIVER: begin
        resValid = owner_onehot;
        if (resReady[owner_q]) begin
          ptr_d   = owner_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign engSt  = st_q;
  assign engPhi = phi_q;
  assign resCos = cos_q;
  assign resSin = sin_q;
  assign resId  = owner_q;

endmodule

// File: tb/tb_cordic_rr_arbiter.sv
// Self-checking bench: timed engine stub, transaction-level reference model,
// directed scenarios and a randomized phase.
module tb_cordic_rr_arbiter;

  localparam int NREQ = 4;
  localparam int PW   = 16;
  localparam int N    = 12;
  localparam int MAXV = 32767;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*PW-1:0]   req_phi = '0;
  logic [NREQ-1:0]      res_ready = '1;
  logic [NREQ-1:0]      reqReady, resValid;
  logic signed [PW-1:0] resCos, resSin;
  logic [1:0]           resId;
  logic                 busy, engSt;
  logic [PW-1:0]        engPhi;
  logic                 eng_rdy;
  logic signed [PW-1:0] eng_cos, eng_sin;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  cordic_rr_arbiter #(.NREQ(NREQ), .PHI_WIDTH(PW), .N(N)) dut (
    .clk(clk), .reset(reset),
    .reqValid(req_valid), .reqPhi(req_phi), .reqReady(reqReady),
    .resValid(resValid), .resReady(res_ready),
    .resCos(resCos), .resSin(resSin), .resId(resId), .busy(busy),
    .engSt(engSt), .engPhi(engPhi),
    .engRdy(eng_rdy), .engCos(eng_cos), .engSin(eng_sin)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, edge_cnt, act, exp);
    end
  endtask

  function automatic logic signed [PW-1:0] ref_trig(input logic [PW-1:0] phi, input bit want_sin);
    real ang, v;
    int  r;
    ang = real'(phi) * 6.283185307179586 / 65536.0;
    v   = (want_sin ? $sin(ang) : $cos(ang)) * real'(MAXV);
    r   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    return r[PW-1:0];
  endfunction

  function automatic bit near(input int a, input int b, input int tol);
    return (a - b <= tol) && (b - a <= tol);
  endfunction

  // Engine stub: rdy one cycle after reset; samples st, rdy low for N+2 edges.
  int            eng_cnt;
  bit            eng_booted;
  logic [PW-1:0] eng_phi_lat;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_rdy <= 1'b0; eng_cnt <= 0; eng_booted <= 1'b0;
      eng_cos <= '0; eng_sin <= '0; eng_phi_lat <= '0;
    end else if (!eng_booted) begin
      eng_booted <= 1'b1;
      eng_rdy    <= 1'b1;
    end else if (engSt) begin
      eng_rdy     <= 1'b0;
      eng_cnt     <= N + 1;
      eng_phi_lat <= engPhi;
      eng_cos     <= 16'sh5A5A;
      eng_sin     <= -16'sh5A5A;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        eng_rdy <= 1'b1;
        eng_cos <= ref_trig(eng_phi_lat, 1'b0);
        eng_sin <= ref_trig(eng_phi_lat, 1'b1);
      end
    end
  end

  // Reference model: one job at a time, timed from its accept edge.
  bit                   m_init;
  int                   m_k, m_ptr, m_owner;
  logic [PW-1:0]        m_phi;
  logic signed [PW-1:0] m_cos, m_sin;

  initial begin
    logic [NREQ-1:0] exp_rr, exp_rv;
    bit exp_busy, exp_st;
    int grant, cyc, idx;
    m_init = 1; m_k = -1; m_ptr = NREQ - 1; m_owner = 0;
    m_phi = '0; m_cos = '0; m_sin = '0;
    forever begin
      @(negedge clk); #2;
      cyc = edge_cnt;
      if (reset) begin
        m_init = 1; m_k = -1; m_ptr = NREQ - 1; m_owner = 0;
        m_phi = '0; m_cos = '0; m_sin = '0;
        check("rst_reqReady", reqReady, 0);
        check("rst_resValid", resValid, 0);
        check("rst_resCos", resCos, 0);
        check("rst_resSin", resSin, 0);
        check("rst_resId", resId, 0);
        check("rst_busy", busy, 1);
        check("rst_engSt", engSt, 0);
        check("rst_engPhi", engPhi, 0);
      end else begin
        exp_rr = '0; exp_rv = '0; exp_busy = 1; exp_st = 0; grant = -1;
        if (m_init) begin
          exp_busy = 1;
        end else if (m_k < 0) begin
          exp_busy = 0;
          for (int j = 1; j <= NREQ; j++) begin
            idx = (m_ptr + j) % NREQ;
            if (grant < 0 && req_valid[idx]) grant = idx;
          end
          if (grant >= 0) exp_rr[grant] = 1'b1;
        end else begin
          if (cyc == m_k) exp_st = 1;
          if (cyc == m_k + N + 3) begin
            m_cos = ref_trig(m_phi, 1'b0);
            m_sin = ref_trig(m_phi, 1'b1);
          end
          if (cyc >= m_k + N + 3) exp_rv[m_owner] = 1'b1;
        end
        check("reqReady", reqReady, exp_rr);
        check("resValid", resValid, exp_rv);
        check("busy", busy, exp_busy);
        check("engSt", engSt, exp_st);
        check("engPhi", engPhi, m_phi);
        check("resId", resId, m_owner);
        check("resCos", resCos, m_cos);
        check("resSin", resSin, m_sin);
        if (m_init) begin
          if (eng_rdy) m_init = 0;
        end else if (m_k < 0) begin
          if (grant >= 0) begin
            m_k = cyc + 1; m_owner = grant; m_phi = req_phi[grant*PW +: PW];
          end
        end else if (cyc >= m_k + N + 3 && res_ready[m_owner]) begin
          m_ptr = m_owner; m_k = -1;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_request(input int id, input logic [PW-1:0] phi, output int acc_cyc);
    bit got = 0;
    @(negedge clk);
    req_phi[id*PW +: PW] = phi;
    req_valid[id] = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      #1;
      if (reqReady[id]) got = 1;
      else @(negedge clk);
    end
    check("accept_timeout", got, 1);
    acc_cyc = edge_cnt;
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_res(input int id, output int at_cyc);
    bit got = 0;
    at_cyc = -1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk); #1;
      if (resValid[id]) begin got = 1; at_cyc = edge_cnt; end
    end
    check("result_timeout", got, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk); #1;
      if (!busy) ok = 1;
    end
    check("idle_timeout", ok, 1);
  endtask

  int t3_phi [3] = '{16'h4000, 16'h8000, 16'hC000};
  int t3_cos [3] = '{0, -MAXV, 0};
  int t3_sin [3] = '{MAXV, 0, -MAXV};

  initial begin
    int acc, rc, gcnt, last_cyc;
    int g_idx [5];
    int g_cyc [5];
    bit ok, got;
    logic signed [PW-1:0] c0, s0;

    #1 reset = 1'b1;
    do_reset();

    // Single job on requester 0, phi = 0.
    res_ready = '1;
    do_request(0, 16'h0000, acc);
    wait_res(0, rc);
    check("t1_latency", rc - (acc + 1), 15);
    check("t1_cos", near(int'(resCos), MAXV, 4), 1);
    check("t1_sin", near(int'(resSin), 0, 4), 1);
    check("t1_resId", resId, 0);
    wait_idle();

    // All requesting, results always consumed.
    do_reset();
    @(negedge clk);
    req_phi = 64'h3000_2000_1000_0800;
    req_valid = '1;
    gcnt = 0;
    for (int n = 0; n < 200 && gcnt < 5; n++) begin
      #1;
      if (reqReady != 0) begin
        g_idx[gcnt] = $clog2(int'(reqReady));
        g_cyc[gcnt] = edge_cnt;
        gcnt++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    check("t2_grant_count", gcnt, 5);
    for (int i = 0; i < 5; i++) begin
      check("t2_grant_order", g_idx[i], i % NREQ);
      if (i > 0) check("t2_grant_spacing", g_cyc[i] - g_cyc[i-1], N + 5);
    end
    wait_idle();

    // Cardinal angles on requester 2.
    for (int i = 0; i < 3; i++) begin
      do_request(2, t3_phi[i][PW-1:0], acc);
      wait_res(2, rc);
      check("t3_cos", near(int'(resCos), t3_cos[i], 4), 1);
      check("t3_sin", near(int'(resSin), t3_sin[i], 4), 1);
      wait_idle();
    end

    // Backpressure on requester 1 while 2 and 3 wait.
    res_ready = '0;
    do_request(1, 16'h2000, acc);
    req_valid[3:2] = 2'b11;
    wait_res(1, rc);
    c0 = resCos; s0 = resSin;
    ok = 1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); #1;
      if (resValid !== 4'b0010 || resCos !== c0 || resSin !== s0 ||
          reqReady !== 4'b0000 || engSt !== 1'b0) ok = 0;
    end
    check("t4_stable", ok, 1);
    @(negedge clk);
    res_ready[1] = 1'b1;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if (reqReady != 0) begin got = 1; check("t4_next_grant", reqReady, 4'b0100); end
      else @(negedge clk);
    end
    check("t4_grant_seen", got, 1);
    @(negedge clk);
    req_valid = '0;
    res_ready = '1;
    wait_idle();

    // Reset while a job for requester 1 is running.
    do_request(1, 16'h3000, acc);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5_outputs_zero", {reqReady, resValid, resCos, resSin, resId, engSt, engPhi}, 0);
    check("t5_busy", busy, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_busy_after_release", busy, 1);
    do_request(3, 16'h2000, acc);
    wait_res(3, rc);
    check("t5_cos", near(int'(resCos), 23170, 4), 1);
    check("t5_sin", near(int'(resSin), 23170, 4), 1);
    check("t5_resId", resId, 3);
    wait_idle();

    // One-cycle request from requester 1 during S_RUN is dropped.
    do_request(0, 16'h0800, acc);
    repeat (2) @(negedge clk);
    req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    ok = 1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk); #1;
      if (reqReady[1] || resValid[1]) ok = 0;
    end
    check("t6_no_grant_1", ok, 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req_valid = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req_phi = {$urandom, $urandom};
      res_ready = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
    end
    @(negedge clk);
    req_valid = '0;
    res_ready = '1;
    wait_idle();
    last_cyc = edge_cnt;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached at cycle %0d", edge_cnt);
    $fatal(1);
  end

endmodule
